// File: rtl/flash_bus_arbiter.sv
// Two-master Wishbone arbiter in front of the flash slave: round-robin grant held
// for the whole cyc, with a watchdog that aborts transfers the slave never acks.
module flash_bus_arbiter #(
  parameter int TIMEOUT_CYC = 64,
  parameter int CNT_W       = 8
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m0_dat_i,
  input  logic [31:0] m1_dat_i,
  output logic [31:0] m0_dat_o,
  output logic [31:0] m1_dat_o,
  input  logic [3:0]  m0_sel_i,
  input  logic [3:0]  m1_sel_i,
  input  logic        m0_we_i,
  input  logic        m1_we_i,
  input  logic        m0_stb_i,
  input  logic        m1_stb_i,
  input  logic        m0_cyc_i,
  input  logic        m1_cyc_i,
  output logic        m0_ack_o,
  output logic        m1_ack_o,
  output logic        m0_err_o,
  output logic        m1_err_o,
  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  output logic [3:0]  s_sel_o,
  output logic        s_we_o,
  output logic        s_stb_o,
  output logic        s_cyc_o,
  input  logic [31:0] s_dat_i,
  input  logic        s_ack_i,
  output logic [1:0]  gnt_o
);

  typedef enum logic [1:0] {IDLE, OWN, ABORT} state_e;

  state_e             state_q, state_d;
  logic               owner_q, owner_d;
  logic               prio_q, prio_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic req0, req1, own_act, owner_cyc, timeout;

  assign req0      = m0_cyc_i & m0_stb_i;
  assign req1      = m1_cyc_i & m1_stb_i;
  assign own_act   = (state_q == OWN);
  assign owner_cyc = owner_q ? m1_cyc_i : m0_cyc_i;
  // ack in the timeout cycle wins, so the abort needs a missing ack as well
  assign timeout   = own_act & s_stb_o & ~s_ack_i &
                     (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

  // Slave side only sees the owner while in OWN; IDLE and ABORT force it idle.
  always_comb begin
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    s_we_o  = 1'b0;
    s_stb_o = 1'b0;
    s_cyc_o = 1'b0;
    if (own_act) begin
      if (owner_q) begin
        s_adr_o = m1_adr_i;
        s_dat_o = m1_dat_i;
        s_sel_o = m1_sel_i;
        s_we_o  = m1_we_i;
        s_stb_o = m1_stb_i;
        s_cyc_o = m1_cyc_i;
      end else begin
        s_adr_o = m0_adr_i;
        s_dat_o = m0_dat_i;
        s_sel_o = m0_sel_i;
        s_we_o  = m0_we_i;
        s_stb_o = m0_stb_i;
        s_cyc_o = m0_cyc_i;
      end
    end
  end

  assign m0_ack_o = own_act & ~owner_q & s_ack_i;
  assign m1_ack_o = own_act &  owner_q & s_ack_i;
  assign m0_err_o = timeout & ~owner_q;
  assign m1_err_o = timeout &  owner_q;
  assign m0_dat_o = (own_act & ~owner_q) ? s_dat_i : 32'h0;
  assign m1_dat_o = (own_act &  owner_q) ? s_dat_i : 32'h0;
  assign gnt_o    = {own_act & owner_q, own_act & ~owner_q};

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    prio_d  = prio_q;
    cnt_d   = '0;
    unique case (state_q)
      IDLE: begin
        if (req0 | req1) begin
          owner_d = (req0 & req1) ? prio_q : req1;
          state_d = OWN;
        end
      end
      OWN: begin
        if (timeout) begin
          state_d = ABORT;
        end else if (!owner_cyc) begin
          state_d = IDLE;
          prio_d  = ~owner_q;
        end else if (s_ack_i) begin
          cnt_d = '0;
        end else if (s_stb_o && cnt_q != '1) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          cnt_d = cnt_q;
        end
      end
      ABORT: begin
        prio_d  = ~owner_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      prio_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      prio_q  <= prio_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
